// File: rtl/p405s_icu_pkg.sv
// Shared ICU package: clog2 helper, default datapath geometry, parameter check macro.
// Latency: n/a (compile-time only).
// Backpressure: n/a.

`ifndef P405S_ICU_PKG_MACROS
`define P405S_ICU_PKG_MACROS
// Elaboration-time guard on a parameter expression; lbl must be unique per use.
`define P405S_ICU_PARAM_CHECK(lbl, cond) \
    if (!(cond)) begin : lbl \
        $error("p405s_icu: parameter out of range"); \
    end
`endif

package p405s_icu_pkg;

    localparam int ICU_DEF_WIDTH = 32;
    localparam int ICU_DEF_DEPTH = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/p405s_icu_dp_regfifo_mem.sv
// DEPTH x WIDTH write-enabled register array (array form of the ICU hold register).
// Latency: write lands on the rising edge; read port is combinational.
// Backpressure: none; the caller gates we.
//
// Ports: clk, we/waddr/wdata write port, raddr/rdata asynchronous read port.

module p405s_icu_dp_regfifo_mem
    import p405s_icu_pkg::*;
#(
    parameter int WIDTH = ICU_DEF_WIDTH,
    parameter int DEPTH = ICU_DEF_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [0:WIDTH-1] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [0:WIDTH-1] rdata
);

    // Contents deliberately have no reset; validity is tracked by the owner.
    logic [0:WIDTH-1] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/p405s_icu_dp_regfifo.sv
// ICU fetch data buffer: DEPTH-entry valid/ready FIFO with flush, optional empty bypass, almost-full.
// Latency: 1 cycle push-to-L2 (0 cycles when BYPASS=1 and empty).
// Backpressure: IN_RDY = not full, from state only; OUT_RDY=0 holds the head on L2.
//
// Ports: CB clock, RSTN sync active-low reset, FLUSH discard-all,
//        IN_VAL/IN_RDY/D fill side, OUT_VAL/OUT_RDY/L2 fetch side,
//        COUNT occupancy, ALMOST_FULL = COUNT >= AFULL_LVL.

module p405s_icu_dp_regfifo
    import p405s_icu_pkg::*;
#(
    parameter int WIDTH     = ICU_DEF_WIDTH,
    parameter int DEPTH     = ICU_DEF_DEPTH,
    parameter int BYPASS    = 0,
    parameter int AFULL_LVL = 3
) (
    input  logic                       CB,
    input  logic                       RSTN,
    input  logic                       FLUSH,
    input  logic                       IN_VAL,
    output logic                       IN_RDY,
    input  logic [0:WIDTH-1]           D,
    output logic                       OUT_VAL,
    input  logic                       OUT_RDY,
    output logic [0:WIDTH-1]           L2,
    output logic [clog2(DEPTH+1)-1:0]  COUNT,
    output logic                       ALMOST_FULL
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    `P405S_ICU_PARAM_CHECK(g_chk_width, WIDTH >= 1)
    `P405S_ICU_PARAM_CHECK(g_chk_depth, DEPTH >= 2 && DEPTH <= 16 && (DEPTH & (DEPTH - 1)) == 0)
    `P405S_ICU_PARAM_CHECK(g_chk_bypass, BYPASS == 0 || BYPASS == 1)
    `P405S_ICU_PARAM_CHECK(g_chk_afull, AFULL_LVL >= 1 && AFULL_LVL <= DEPTH)

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [0:WIDTH-1] rd_data;

    logic empty;
    logic full;
    logic byp_act;
    logic push;
    logic pop;
    logic byp_pop;
    logic wr_en;
    logic rd_adv;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign byp_act = (BYPASS != 0) && empty;

    assign IN_RDY      = !full;
    assign OUT_VAL     = !FLUSH && (byp_act ? IN_VAL : !empty);
    assign L2          = !OUT_VAL ? '0 : (byp_act ? D : rd_data);
    assign COUNT       = count_q;
    assign ALMOST_FULL = (count_q >= AFULL_C);

    assign push = IN_VAL && IN_RDY && !FLUSH;
    assign pop  = OUT_VAL && OUT_RDY && !FLUSH;

    // A bypassed word taken in the same cycle never touches storage or pointers.
    assign byp_pop = byp_act && pop;
    assign wr_en   = push && !byp_pop;
    assign rd_adv  = pop && !byp_pop;

    always_ff @(posedge CB) begin
        if (!RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (FLUSH) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (wr_en && !rd_adv) begin
                count_q <= count_q + CW'(1);
            end else if (rd_adv && !wr_en) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Write enable is qualified by RSTN so a reset cycle cannot deposit data.
    p405s_icu_dp_regfifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (CB),
        .we    (wr_en && RSTN),
        .waddr (wr_ptr_q),
        .wdata (D),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_p405s_icu_dp_regfifo.sv
module tb_p405s_icu_dp_regfifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- main DUT: defaults, BYPASS=0 ----------------
    logic        in_val, out_rdy, flush;
    logic [0:31] din;
    logic        in_rdy, out_val, afull;
    logic [0:31] l2;
    logic [2:0]  count;

    p405s_icu_dp_regfifo dut (
        .CB(clk), .RSTN(rstn), .FLUSH(flush), .IN_VAL(in_val), .IN_RDY(in_rdy), .D(din),
        .OUT_VAL(out_val), .OUT_RDY(out_rdy), .L2(l2), .COUNT(count), .ALMOST_FULL(afull)
    );

    // ---------------- bypass DUT ----------------
    logic        b_in_val, b_out_rdy, b_flush;
    logic [0:31] b_d;
    logic        b_in_rdy, b_out_val, b_afull;
    logic [0:31] b_l2;
    logic [2:0]  b_count;

    p405s_icu_dp_regfifo #(.BYPASS(1)) dut_byp (
        .CB(clk), .RSTN(rstn), .FLUSH(b_flush), .IN_VAL(b_in_val), .IN_RDY(b_in_rdy), .D(b_d),
        .OUT_VAL(b_out_val), .OUT_RDY(b_out_rdy), .L2(b_l2), .COUNT(b_count), .ALMOST_FULL(b_afull)
    );

    // ---------------- WIDTH=64, DEPTH=2 ----------------
    logic        w_in_val, w_out_rdy, w_flush;
    logic [0:63] w_d;
    logic        w_in_rdy, w_out_val, w_afull;
    logic [0:63] w_l2;
    logic [1:0]  w_count;

    p405s_icu_dp_regfifo #(.WIDTH(64), .DEPTH(2), .AFULL_LVL(2)) dut_w64 (
        .CB(clk), .RSTN(rstn), .FLUSH(w_flush), .IN_VAL(w_in_val), .IN_RDY(w_in_rdy), .D(w_d),
        .OUT_VAL(w_out_val), .OUT_RDY(w_out_rdy), .L2(w_l2), .COUNT(w_count), .ALMOST_FULL(w_afull)
    );

    // ---------------- DEPTH=16 ----------------
    logic        s_in_val, s_out_rdy, s_flush;
    logic [0:31] s_d;
    logic        s_in_rdy, s_out_val, s_afull;
    logic [0:31] s_l2;
    logic [4:0]  s_count;

    p405s_icu_dp_regfifo #(.DEPTH(16), .AFULL_LVL(15)) dut_d16 (
        .CB(clk), .RSTN(rstn), .FLUSH(s_flush), .IN_VAL(s_in_val), .IN_RDY(s_in_rdy), .D(s_d),
        .OUT_VAL(s_out_val), .OUT_RDY(s_out_rdy), .L2(s_l2), .COUNT(s_count), .ALMOST_FULL(s_afull)
    );

    // ---------------- scoreboard for the main DUT ----------------
    logic [31:0] exp_q[$];
    logic        mon_en = 1'b0;

    // Queue size equals expected COUNT at every negedge; handshakes pop the head.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_count", 64'(count), 64'(exp_q.size()));
            chk("mon_out_val", 64'(out_val), 64'((exp_q.size() != 0) && !flush));
            chk("mon_in_rdy", 64'(in_rdy), 64'(exp_q.size() != 4));
            chk("mon_afull", 64'(afull), 64'(exp_q.size() >= 3));
            if (out_val) begin
                if (exp_q.size() == 0) begin
                    chk("mon_l2_unexpected", 64'(l2), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("mon_l2", 64'(l2), 64'(exp_q[0]));
                    if (out_rdy && !flush) void'(exp_q.pop_front());
                end
            end else begin
                chk("mon_l2_idle", 64'(l2), 64'd0);
            end
        end
    end

    // One main-DUT cycle; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic r, input logic iv, input logic [31:0] d,
                        input logic ordy, input logic fl);
        logic acc;
        rstn = r; in_val = iv; din = d; out_rdy = ordy; flush = fl;
        acc = r && iv && !fl && (exp_q.size() < 4);
        @(posedge clk);
        if (!r || fl) exp_q.delete();
        else if (acc) exp_q.push_back(d);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        in_val = 0; out_rdy = 0; flush = 0; din = '0;
        b_in_val = 0; b_out_rdy = 0; b_flush = 0; b_d = '0;
        w_in_val = 0; w_out_rdy = 0; w_flush = 0; w_d = '0;
        s_in_val = 0; s_out_rdy = 0; s_flush = 0; s_d = '0;
        @(posedge clk); #1;

        // Reset with a word offered: nothing may be captured.
        step(0, 1, 32'hDEADBEEF, 0, 0);
        step(0, 1, 32'hDEADBEEF, 0, 0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_l2", 64'(l2), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        chk("rst_afull", 64'(afull), 64'd0);
        mon_en = 1'b1;
        step(1, 0, 32'h0, 1, 0);

        // Fill to full, then a fifth word that must be dropped.
        for (int i = 1; i <= 4; i++) step(1, 1, 32'(i), 0, 0);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_rdy", 64'(in_rdy), 64'd0);
        chk("fill_afull", 64'(afull), 64'd1);
        step(1, 1, 32'h5, 0, 0);
        chk("full_ignored_count", 64'(count), 64'd4);
        chk("full_head", 64'(l2), 64'h1);
        for (int i = 0; i < 4; i++) step(1, 0, 32'h0, 1, 0);
        chk("drain_out_val", 64'(out_val), 64'd0);
        step(1, 0, 32'h0, 1, 0);
        chk("empty_no_underflow", 64'(count), 64'd0);

        // Steady push+pop at COUNT=2 across pointer wrap.
        step(1, 1, 32'h100, 0, 0);
        step(1, 1, 32'h101, 0, 0);
        for (int i = 2; i < 12; i++) step(1, 1, 32'h100 + 32'(i), 1, 0);
        chk("stream_count", 64'(count), 64'd2);
        chk("stream_head", 64'(l2), 64'h10A);
        step(1, 0, 32'h0, 1, 0);
        step(1, 0, 32'h0, 1, 0);

        // Flush with push and pop requested in the same cycle.
        for (int i = 0; i < 3; i++) step(1, 1, 32'h200 + 32'(i), 0, 0);
        chk("preflush_count", 64'(count), 64'd3);
        step(1, 1, 32'h2FF, 1, 1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_val", 64'(out_val), 64'd0);
        step(1, 1, 32'h300, 0, 0);
        chk("post_flush_head", 64'(l2), 64'h300);
        step(1, 0, 32'h0, 1, 0);
        step(1, 0, 32'h0, 0, 0);
        mon_en = 1'b0;

        // Bypass: empty, consumer ready -> same-cycle pass-through, no storage.
        b_in_val = 1; b_d = 32'hA5A5A5A5; b_out_rdy = 1;
        #1;
        chk("byp_out_val", 64'(b_out_val), 64'd1);
        chk("byp_l2", 64'(b_l2), 64'hA5A5A5A5);
        tick();
        chk("byp_count_stays0", 64'(b_count), 64'd0);
        // Consumer stalled -> the word is stored.
        b_out_rdy = 0;
        #1;
        chk("byp_stall_out_val", 64'(b_out_val), 64'd1);
        tick();
        b_in_val = 0; b_d = 32'h0;
        #1;
        chk("byp_stall_count", 64'(b_count), 64'd1);
        chk("byp_stall_l2", 64'(b_l2), 64'hA5A5A5A5);
        b_out_rdy = 1;
        tick();
        chk("byp_pop_count", 64'(b_count), 64'd0);
        // Flush masks the bypass path.
        b_in_val = 1; b_d = 32'h12345678; b_flush = 1;
        #1;
        chk("byp_flush_out_val", 64'(b_out_val), 64'd0);
        tick();
        chk("byp_flush_count", 64'(b_count), 64'd0);
        b_in_val = 0; b_flush = 0; b_out_rdy = 0;

        // WIDTH=64, DEPTH=2.
        w_in_val = 1; w_d = 64'h0123456789ABCDEF;
        tick();
        chk("w64_count1", 64'(w_count), 64'd1);
        chk("w64_afull1", 64'(w_afull), 64'd0);
        chk("w64_in_rdy1", 64'(w_in_rdy), 64'd1);
        w_d = 64'hFEDCBA9876543210;
        tick();
        chk("w64_count2", 64'(w_count), 64'd2);
        chk("w64_in_rdy2", 64'(w_in_rdy), 64'd0);
        chk("w64_afull2", 64'(w_afull), 64'd1);
        w_d = 64'h1111111111111111;
        tick();
        chk("w64_full_hold", 64'(w_count), 64'd2);
        w_in_val = 0; w_out_rdy = 1;
        #1;
        chk("w64_head0", 64'(w_l2), 64'h0123456789ABCDEF);
        tick();
        chk("w64_head1", 64'(w_l2), 64'hFEDCBA9876543210);
        tick();
        chk("w64_empty", 64'(w_out_val), 64'd0);
        chk("w64_count0", 64'(w_count), 64'd0);
        w_out_rdy = 0;

        // DEPTH=16 fill to COUNT=16, overflow attempt, then ordered drain.
        s_in_val = 1;
        for (int i = 0; i < 16; i++) begin
            s_d = 32'h4000 + 32'(i);
            tick();
        end
        chk("d16_count_full", 64'(s_count), 64'd16);
        chk("d16_in_rdy", 64'(s_in_rdy), 64'd0);
        chk("d16_afull", 64'(s_afull), 64'd1);
        s_d = 32'hBAD0BAD0;
        tick();
        chk("d16_overflow_ignored", 64'(s_count), 64'd16);
        s_in_val = 0; s_out_rdy = 1;
        for (int i = 0; i < 16; i++) begin
            chk("d16_order", 64'(s_l2), 64'(32'h4000 + 32'(i)));
            tick();
        end
        chk("d16_empty", 64'(s_out_val), 64'd0);
        chk("d16_count0", 64'(s_count), 64'd0);
        s_out_rdy = 0;

        if (exp_q.size() != 0) chk("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net: never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
